// File: rtl/me_sw_shift_feeder.sv
// Source end of the search-window byte-shift chain: holds the current window row W and the
// following row N, and feeds one byte per shift into the window.
module me_sw_shift_feeder #(
    parameter int ROW_BYTES = 16,
    parameter int CNT_W     = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   flush_i,
    input  logic                   row_valid_i,
    output logic                   row_ready_o,
    input  logic [8*ROW_BYTES-1:0] row_data_i,
    input  logic                   shift_en_i,
    output logic                   win_valid_o,
    output logic [8*ROW_BYTES-1:0] win_data_o,
    output logic [15:0]            pair_o,
    output logic [CNT_W-1:0]       step_cnt_o,
    output logic                   row_done_o
);

    localparam int                ROW_W    = 8 * ROW_BYTES;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ROW_BYTES - 1);

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_PRIME,
        ST_RUN
    } state_e;

    state_e             state_q, state_d;
    logic [ROW_W-1:0]   win_q;
    logic [ROW_W-1:0]   next_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               row_done_q;

    logic               row_accept;
    logic               run_shift;
    logic               last_shift;

    assign run_shift  = (state_q == ST_RUN) && shift_en_i;
    assign last_shift = run_shift && (cnt_q == CNT_LAST);
    // A flush drops any row offered in the same cycle even though ready is high.
    assign row_accept = row_valid_i && row_ready_o && !flush_i;

    // ---------------------------------------------------------------- state register
    // NOTE: sequential state is updated with non-blocking assignments only, so every
    // register samples the pre-edge value of the others.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------- next state
    // NOTE: a default assignment first keeps this block from inferring a latch.
    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: if (row_accept) state_d = ST_PRIME;
                ST_PRIME: if (row_accept) state_d = ST_RUN;
                ST_RUN:   if (last_shift && !row_valid_i) state_d = ST_PRIME;
                default:  state_d = ST_EMPTY;
            endcase
        end
    end

    // ---------------------------------------------------------------- outputs
    // In RUN, ready is combinational from shift_en_i so the next row loads in the very
    // cycle the 16th byte leaves N, giving bubble-free row changes.
    always_comb begin
        row_ready_o = 1'b0;
        win_valid_o = 1'b0;
        pair_o      = '0;
        case (state_q)
            ST_EMPTY: begin
                row_ready_o = 1'b1;
            end
            ST_PRIME: begin
                row_ready_o = 1'b1;
                win_valid_o = 1'b1;
            end
            ST_RUN: begin
                row_ready_o = last_shift;
                win_valid_o = 1'b1;
                pair_o      = next_q[15:0];
            end
            default: ;
        endcase
        if (flush_i) row_ready_o = 1'b1;
    end

    // ---------------------------------------------------------------- datapath
    // NOTE: W and N are reset explicitly; they are plain registers, not a memory, and
    // the zero window is observable on win_data_o.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            win_q      <= '0;
            next_q     <= '0;
            cnt_q      <= '0;
            row_done_q <= 1'b0;
        end else if (flush_i) begin
            win_q      <= '0;
            next_q     <= '0;
            cnt_q      <= '0;
            row_done_q <= 1'b0;
        end else begin
            row_done_q <= last_shift;
            case (state_q)
                ST_EMPTY: begin
                    if (row_accept) win_q <= row_data_i;
                end
                ST_PRIME: begin
                    if (row_accept) begin
                        next_q <= row_data_i;
                        cnt_q  <= '0;
                    end
                end
                ST_RUN: begin
                    if (run_shift) begin
                        win_q  <= {next_q[7:0], win_q[ROW_W-1:8]};
                        next_q <= {8'h00, next_q[ROW_W-1:8]};
                        cnt_q  <= cnt_q + 1'b1;
                    end
                    // The new row overrides the shift of the exhausted N.
                    if (row_accept) begin
                        next_q <= row_data_i;
                        cnt_q  <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign win_data_o = win_q;
    assign step_cnt_o = cnt_q;
    assign row_done_o = row_done_q;

endmodule

// File: tb/tb_me_sw_shift_feeder.sv
// Directed bench for me_sw_shift_feeder: row fill, shifting, seamless and stalled row
// changes, flush and asynchronous reset.
module tb_me_sw_shift_feeder;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         flush_i;
    logic         row_valid_i;
    logic         row_ready_o;
    logic [127:0] row_data_i;
    logic         shift_en_i;
    logic         win_valid_o;
    logic [127:0] win_data_o;
    logic [15:0]  pair_o;
    logic [3:0]   step_cnt_o;
    logic         row_done_o;

    int errors = 0;
    int checks = 0;

    logic [127:0] row_a, row_b, row_c, row_d, row_e;

    me_sw_shift_feeder dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .row_valid_i (row_valid_i),
        .row_ready_o (row_ready_o),
        .row_data_i  (row_data_i),
        .shift_en_i  (shift_en_i),
        .win_valid_o (win_valid_o),
        .win_data_o  (win_data_o),
        .pair_o      (pair_o),
        .step_cnt_o  (step_cnt_o),
        .row_done_o  (row_done_o)
    );

    always #5 clk_i = ~clk_i;

    // Row whose byte k equals base+k.
    function automatic logic [127:0] mk_row(input logic [7:0] base);
        logic [127:0] r;
        for (int k = 0; k < 16; k++) r[8*k +: 8] = base + 8'(k);
        return r;
    endfunction

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; flush_i = 1'b0; row_valid_i = 1'b0; shift_en_i = 1'b0;
        row_data_i = '0;
        #12;
        checks++; if (win_valid_o !== 1'b0) begin errors++; $display("FAIL reset_win_valid got=%b exp=0", win_valid_o); end
        checks++; if (win_data_o !== 128'h0) begin errors++; $display("FAIL reset_win_data got=%h exp=0", win_data_o); end
        checks++; if (pair_o !== 16'h0) begin errors++; $display("FAIL reset_pair got=%h exp=0", pair_o); end
        checks++; if (step_cnt_o !== 4'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", step_cnt_o); end
        checks++; if (row_done_o !== 1'b0) begin errors++; $display("FAIL reset_row_done got=%b exp=0", row_done_o); end
        checks++; if (row_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", row_ready_o); end
        rst_i = 1'b0;
        tick();
    endtask

    task automatic test_fill();
        row_valid_i = 1'b1; row_data_i = row_a;
        tick();
        checks++; if (win_valid_o !== 1'b1) begin errors++; $display("FAIL prime_win_valid got=%b exp=1", win_valid_o); end
        checks++; if (win_data_o !== row_a) begin errors++; $display("FAIL prime_win got=%h exp=%h", win_data_o, row_a); end
        checks++; if (pair_o !== 16'h0) begin errors++; $display("FAIL prime_pair got=%h exp=0", pair_o); end
        checks++; if (row_ready_o !== 1'b1) begin errors++; $display("FAIL prime_ready got=%b exp=1", row_ready_o); end
        row_data_i = row_b;
        tick();
        row_valid_i = 1'b0; row_data_i = row_e;
        #1;
        checks++; if (win_data_o !== row_a) begin errors++; $display("FAIL run_win got=%h exp=%h", win_data_o, row_a); end
        checks++; if (pair_o !== 16'h1110) begin errors++; $display("FAIL run_pair got=%h exp=1110", pair_o); end
        checks++; if (step_cnt_o !== 4'd0) begin errors++; $display("FAIL run_cnt got=%0d exp=0", step_cnt_o); end
        checks++; if (row_ready_o !== 1'b0) begin errors++; $display("FAIL run_ready got=%b exp=0", row_ready_o); end
    endtask

    task automatic test_single_shift();
        logic [127:0] exp_w;
        exp_w = {8'h10, row_a[127:8]};
        shift_en_i = 1'b1;
        tick();
        shift_en_i = 1'b0;
        checks++; if (win_data_o[7:0] !== 8'h01) begin errors++; $display("FAIL shift1_byte0 got=%h exp=01", win_data_o[7:0]); end
        checks++; if (win_data_o[127:120] !== 8'h10) begin errors++; $display("FAIL shift1_byte15 got=%h exp=10", win_data_o[127:120]); end
        checks++; if (win_data_o !== exp_w) begin errors++; $display("FAIL shift1_win got=%h exp=%h", win_data_o, exp_w); end
        checks++; if (pair_o !== 16'h1211) begin errors++; $display("FAIL shift1_pair got=%h exp=1211", pair_o); end
        checks++; if (step_cnt_o !== 4'd1) begin errors++; $display("FAIL shift1_cnt got=%0d exp=1", step_cnt_o); end
    endtask

    // Fifteen more shifts finish row B with row C offered throughout.
    task automatic test_back_to_back();
        row_valid_i = 1'b1; row_data_i = row_c; shift_en_i = 1'b1;
        for (int i = 1; i < 16; i++) begin
            #1;
            checks++; if (row_ready_o !== (i == 15)) begin errors++; $display("FAIL b2b_ready step=%0d got=%b exp=%b", i, row_ready_o, (i == 15)); end
            checks++; if (row_done_o !== 1'b0) begin errors++; $display("FAIL b2b_early_done step=%0d got=%b exp=0", i, row_done_o); end
            tick();
        end
        shift_en_i = 1'b0; row_valid_i = 1'b0; row_data_i = row_e;
        #1;
        checks++; if (win_data_o !== row_b) begin errors++; $display("FAIL b2b_win got=%h exp=%h", win_data_o, row_b); end
        checks++; if (pair_o !== 16'h2120) begin errors++; $display("FAIL b2b_pair got=%h exp=2120", pair_o); end
        checks++; if (step_cnt_o !== 4'd0) begin errors++; $display("FAIL b2b_cnt got=%0d exp=0", step_cnt_o); end
        checks++; if (row_done_o !== 1'b1) begin errors++; $display("FAIL b2b_done got=%b exp=1", row_done_o); end
        tick();
        checks++; if (row_done_o !== 1'b0) begin errors++; $display("FAIL b2b_done_width got=%b exp=0", row_done_o); end
        checks++; if (win_data_o !== row_b) begin errors++; $display("FAIL b2b_hold got=%h exp=%h", win_data_o, row_b); end
    endtask

    task automatic test_stall();
        logic        pat [4];
        logic [3:0]  exp_cnt [4];
        logic [127:0] exp_w [4];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        exp_cnt = '{4'd1, 4'd1, 4'd1, 4'd2};
        exp_w[0] = {row_c[7:0], row_b[127:8]};
        exp_w[1] = exp_w[0];
        exp_w[2] = exp_w[0];
        exp_w[3] = {row_c[15:0], row_b[127:16]};
        for (int i = 0; i < 4; i++) begin
            shift_en_i = pat[i];
            tick();
            checks++; if (step_cnt_o !== exp_cnt[i]) begin errors++; $display("FAIL stall_cnt i=%0d got=%0d exp=%0d", i, step_cnt_o, exp_cnt[i]); end
            checks++; if (win_data_o !== exp_w[i]) begin errors++; $display("FAIL stall_win i=%0d got=%h exp=%h", i, win_data_o, exp_w[i]); end
        end
        shift_en_i = 1'b0;
    endtask

    // Finish row C with no next row offered: drops to PRIME, then D restarts RUN.
    task automatic test_prime_fallback();
        shift_en_i = 1'b1;
        for (int i = 0; i < 14; i++) tick();
        shift_en_i = 1'b0;
        #1;
        checks++; if (win_data_o !== row_c) begin errors++; $display("FAIL fb_win got=%h exp=%h", win_data_o, row_c); end
        checks++; if (pair_o !== 16'h0) begin errors++; $display("FAIL fb_pair got=%h exp=0", pair_o); end
        checks++; if (row_ready_o !== 1'b1) begin errors++; $display("FAIL fb_ready got=%b exp=1", row_ready_o); end
        checks++; if (row_done_o !== 1'b1) begin errors++; $display("FAIL fb_done got=%b exp=1", row_done_o); end
        checks++; if (win_valid_o !== 1'b1) begin errors++; $display("FAIL fb_win_valid got=%b exp=1", win_valid_o); end
        shift_en_i = 1'b1;
        tick();
        tick();
        shift_en_i = 1'b0;
        checks++; if (win_data_o !== row_c) begin errors++; $display("FAIL fb_shift_ignored got=%h exp=%h", win_data_o, row_c); end
        checks++; if (row_done_o !== 1'b0) begin errors++; $display("FAIL fb_done_clear got=%b exp=0", row_done_o); end
        row_valid_i = 1'b1; row_data_i = row_d;
        tick();
        row_valid_i = 1'b0; row_data_i = row_e;
        checks++; if (pair_o !== 16'h3130) begin errors++; $display("FAIL fb_reload_pair got=%h exp=3130", pair_o); end
        checks++; if (win_data_o !== row_c) begin errors++; $display("FAIL fb_reload_win got=%h exp=%h", win_data_o, row_c); end
        checks++; if (step_cnt_o !== 4'd0) begin errors++; $display("FAIL fb_reload_cnt got=%0d exp=0", step_cnt_o); end
    endtask

    // Flush lands on the 16th shift with a row offered: nothing survives.
    task automatic test_flush();
        shift_en_i = 1'b1;
        for (int i = 0; i < 15; i++) tick();
        checks++; if (step_cnt_o !== 4'd15) begin errors++; $display("FAIL flush_pre_cnt got=%0d exp=15", step_cnt_o); end
        flush_i = 1'b1; row_valid_i = 1'b1; row_data_i = row_e;
        tick();
        flush_i = 1'b0; row_valid_i = 1'b0; shift_en_i = 1'b0;
        #1;
        checks++; if (win_valid_o !== 1'b0) begin errors++; $display("FAIL flush_win_valid got=%b exp=0", win_valid_o); end
        checks++; if (win_data_o !== 128'h0) begin errors++; $display("FAIL flush_win got=%h exp=0", win_data_o); end
        checks++; if (step_cnt_o !== 4'd0) begin errors++; $display("FAIL flush_cnt got=%0d exp=0", step_cnt_o); end
        checks++; if (row_ready_o !== 1'b1) begin errors++; $display("FAIL flush_ready got=%b exp=1", row_ready_o); end
        checks++; if (row_done_o !== 1'b0) begin errors++; $display("FAIL flush_done got=%b exp=0", row_done_o); end
        checks++; if (pair_o !== 16'h0) begin errors++; $display("FAIL flush_pair got=%h exp=0", pair_o); end
        tick();
        checks++; if (win_valid_o !== 1'b0) begin errors++; $display("FAIL flush_row_dropped got=%b exp=0", win_valid_o); end
        checks++; if (row_done_o !== 1'b0) begin errors++; $display("FAIL flush_done_late got=%b exp=0", row_done_o); end
    endtask

    task automatic test_async_reset();
        row_valid_i = 1'b1; row_data_i = row_a;
        tick();
        row_data_i = row_b;
        tick();
        row_valid_i = 1'b0; shift_en_i = 1'b1;
        tick();
        tick();
        shift_en_i = 1'b0;
        checks++; if (step_cnt_o !== 4'd2) begin errors++; $display("FAIL arst_pre_cnt got=%0d exp=2", step_cnt_o); end
        #2;
        rst_i = 1'b1; row_valid_i = 1'b1; row_data_i = row_e; shift_en_i = 1'b1;
        #1;
        checks++; if (win_valid_o !== 1'b0) begin errors++; $display("FAIL arst_win_valid got=%b exp=0", win_valid_o); end
        checks++; if (win_data_o !== 128'h0) begin errors++; $display("FAIL arst_win got=%h exp=0", win_data_o); end
        checks++; if (step_cnt_o !== 4'd0) begin errors++; $display("FAIL arst_cnt got=%0d exp=0", step_cnt_o); end
        checks++; if (row_ready_o !== 1'b1) begin errors++; $display("FAIL arst_ready got=%b exp=1", row_ready_o); end
        tick();
        rst_i = 1'b0; row_valid_i = 1'b0; shift_en_i = 1'b0;
        tick();
        checks++; if (win_valid_o !== 1'b0) begin errors++; $display("FAIL arst_row_dropped got=%b exp=0", win_valid_o); end
        checks++; if (row_done_o !== 1'b0) begin errors++; $display("FAIL arst_done got=%b exp=0", row_done_o); end
    endtask

    initial begin
        row_a = mk_row(8'h00);
        row_b = mk_row(8'h10);
        row_c = mk_row(8'h20);
        row_d = mk_row(8'h30);
        row_e = mk_row(8'h40);
        test_reset();
        test_fill();
        test_single_shift();
        test_back_to_back();
        test_stall();
        test_prime_fallback();
        test_flush();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/me_sw_shift_feeder.md
Name: me_sw_shift_feeder

Overview:
- Source side of the search-window byte-shift chain: holds the current 128-bit window row and the next 128-bit row, and shifts one byte per cycle.
- Each step presents the window plus the 16-bit byte-pair bus in the format the shift stages consume: [7:0] is the byte entering now, [15:8] is the byte entering next.
- Rows arrive from reference memory over a valid/ready handshake.
- Back-to-back rows shift seamlessly, with no bubble between them.

Parameters:
- ROW_BYTES, 16, bytes per row word; row width = 8*ROW_BYTES. Only 16 is verified.
- CNT_W, 4, step counter width; must equal log2(ROW_BYTES).

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  asynchronous active-high reset.
- flush_i  input  1  synchronous clear to EMPTY.
- row_valid_i  input  1  row word offered.
- row_ready_o  output  1  row word accepted this cycle when high together with row_valid_i.
- row_data_i  input  128  row word; byte k = bits [8k+7:8k].
- shift_en_i  input  1  consumer requests a one-byte shift.
- win_valid_o  output  1  window contents valid.
- win_data_o  output  128  current window W.
- pair_o  output  16  N[15:0] in RUN, 0 otherwise.
- step_cnt_o  output  4  shifts done on the current next-row (0..15).
- row_done_o  output  1  one-cycle pulse, registered, in the cycle after the 16th shift of a row.

Behaviour:
- Internal registers: window W, next row N, counter cnt, state ∈ {EMPTY, PRIME, RUN}.

Reset (rst_i=1, asynchronous):
- W, N, cnt and row_done_o are cleared to 0; state = EMPTY.
- All outputs read 0 except row_ready_o=1.

flush_i (synchronous):
- Highest priority.
- Next state is EMPTY, W, N, cnt and row_done_o are cleared, and any concurrent row handshake or shift is discarded.
- row_ready_o stays high during flush, but the row is dropped.

EMPTY:
- row_ready_o=1, win_valid_o=0.
- Row accept: W<=row_data_i, go to PRIME.
- shift_en_i is ignored.

PRIME:
- row_ready_o=1, win_valid_o=1, pair_o=0.
- Row accept: N<=row_data_i, cnt<=0, go to RUN.
- shift_en_i is ignored (no incoming bytes), so W holds.

RUN:
- win_valid_o=1, pair_o=N[15:0].
- Shift (shift_en_i=1):
  - W <= {N[7:0], W[127:8]}
  - N <= {8'h00, N[127:8]}
  - cnt <= cnt+1 (wraps at 15)
- No shift: W, N and cnt hold.
- row_ready_o = (cnt==15) & shift_en_i. This is a combinational path from shift_en_i, which is allowed and documented.
- When cnt==15 and a shift occurs, the 16th shift completes and W then equals the original next row. Next state:
  - row_valid_i=1: N<=row_data_i (the shift of the old N is overridden by the load), cnt<=0, stay in RUN. This is the seamless case.
  - row_valid_i=0: go to PRIME; N contents become don't-care, pair_o reads 0.
- row_done_o=1 in the cycle after any 16th shift, whether or not a new row was loaded.

General rules:
- row_data_i is sampled only on accept; it is ignored otherwise.
- Latency: a shift is visible on win_data_o and pair_o in the cycle after shift_en_i is sampled.
- No data is lost on a stall: the consumer may hold shift_en_i=0 for any number of cycles.

Test Plan:
- Reset, then offer row A (byte k=k) followed by row B (byte k=0x10+k), with no shifts -> state reaches RUN; win_data_o=A; pair_o=0x1110; step_cnt_o=0; row_ready_o=0.
- From that state, pulse shift_en_i once -> win byte0=0x01, byte15=0x10; pair_o=0x1211; step_cnt_o=1.
- Shift 16 consecutive cycles with row C (0x20+k) valid throughout -> after the 16th shift win_data_o=B, pair_o=0x2120, step_cnt_o=0, row_done_o high for exactly 1 cycle, and C is accepted in the same cycle as the 16th shift.
- Repeat with row_valid_i=0 at the 16th shift -> state goes to PRIME, win_data_o=B, pair_o=0; further shift_en_i pulses leave W unchanged; offering C then returns to RUN with pair_o=0x2120.
- Interleave shift_en_i 1,0,0,1 -> step_cnt_o goes 1,1,1,2 and W changes only on shift cycles.
- Assert flush_i with row_valid_i=1 and shift_en_i=1 mid-row, and separately assert rst_i asynchronously mid-cycle -> both give win_valid_o=0, W=0, step_cnt_o=0, row_ready_o=1, no row_done_o pulse, and the offered row is not captured.
